unidad_saltos: RTL and testbench

Parametrised branch-decision unit for the CPU control path. Latches the ALU flags and evaluates an 8-way condition code for each issued jump-class instruction. Drives a registered, single-cycle `pre_load` pulse and target address to the program counter. Adds call/return through an internal return-address stack with sticky overflow/underflow reporting, and carry-conditional jumps now actually load.

---
 rtl/unidad_saltos_if.sv | 31 +++
 rtl/unidad_saltos.sv | 146 ++++++++++++++
 tb/tb_unidad_saltos.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/unidad_saltos_if.sv
// unidad_saltos_if: flag/jump/stack bus between the control path and the
// branch-decision unit. "master" drives the instruction side, "slave" is the
// branch unit itself.
interface unidad_saltos_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 8
);
  logic             flag_we;
  logic [WIDTH-1:0] W;
  logic             CY;
  logic             instr_valid;
  logic [2:0]       cond_sel;
  logic [AW-1:0]    target;
  logic [AW-1:0]    pc_seq;
  logic             err_clr;
  logic             pre_load;
  logic [AW-1:0]    load_addr;
  logic [4:0]       stack_cnt;
  logic             stack_ovf;
  logic             stack_unf;

  modport master (
    output flag_we, W, CY, instr_valid, cond_sel, target, pc_seq, err_clr,
    input  pre_load, load_addr, stack_cnt, stack_ovf, stack_unf
  );

  modport slave (
    input  flag_we, W, CY, instr_valid, cond_sel, target, pc_seq, err_clr,
    output pre_load, load_addr, stack_cnt, stack_ovf, stack_unf
  );
endinterface

// File: rtl/unidad_saltos.sv
// unidad_saltos: branch-decision unit. Latches ALU flags, evaluates the
// 8-way condition code of each issued jump-class instruction and produces a
// registered one-cycle PC load strobe plus target address. call/ret use an
// internal return-address stack with sticky overflow/underflow flags.
// Optional feature: define UNIDAD_SALTOS_FLAG_BYPASS_EN to let a condition
// issued together with flag_we see the freshly computed flags.
module unidad_saltos #(
  parameter int WIDTH = 16,
  parameter int AW    = 8,
  parameter int DEPTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  unidad_saltos_if.slave  bus
);

  typedef enum logic [2:0] {
    C_JMP  = 3'b000,
    C_JZE  = 3'b001,
    C_JNE  = 3'b010,
    C_CCY  = 3'b011,
    C_CALL = 3'b100,
    C_RET  = 3'b101,
    C_JNZ  = 3'b110,
    C_RSV  = 3'b111
  } cond_e;

  localparam int         PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_CNT = 5'(DEPTH);

  // Registered flags
  logic z_q, n_q, c_q;

  // Outputs and stack state
  logic          pre_load_q;
  logic [AW-1:0] load_addr_q;
  logic [4:0]    stack_cnt_q;
  logic          ovf_q, unf_q;
  logic [AW-1:0] stack_mem [DEPTH];

  // Decision results
  logic          z_eff, n_eff, c_eff;
  logic          take, push, pop, set_ovf, set_unf;
  logic [AW-1:0] sel_addr;
  logic          stack_full, stack_empty;
  logic [PW-1:0] push_idx, top_idx;
  cond_e         cond;

  assign cond        = cond_e'(bus.cond_sel);
  assign stack_full  = (stack_cnt_q == DEPTH_CNT);
  assign stack_empty = (stack_cnt_q == 5'd0);
  assign push_idx    = PW'(stack_cnt_q);
  assign top_idx     = PW'(stack_cnt_q - 5'd1);

  // Flags seen by the condition: registered, or current ALU result when bypassing
`ifdef UNIDAD_SALTOS_FLAG_BYPASS_EN
  assign z_eff = bus.flag_we ? (bus.W == '0)       : z_q;
  assign n_eff = bus.flag_we ? bus.W[WIDTH-1]      : n_q;
  assign c_eff = bus.flag_we ? bus.CY              : c_q;
`else
  assign z_eff = z_q;
  assign n_eff = n_q;
  assign c_eff = c_q;
`endif

  // Condition evaluation and stack request decode
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    take     = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    set_ovf  = 1'b0;
    set_unf  = 1'b0;
    sel_addr = bus.target;
    if (bus.instr_valid) begin
      unique case (cond)
        C_JMP:  take = 1'b1;
        C_JZE:  take = z_eff;
        C_JNE:  take = n_eff;
        C_CCY:  take = c_eff;
        C_JNZ:  take = !z_eff;
        C_CALL: begin
          if (stack_full) set_ovf = 1'b1;
          else begin
            take = 1'b1;
            push = 1'b1;
          end
        end
        C_RET: begin
          if (stack_empty) set_unf = 1'b1;
          else begin
            take     = 1'b1;
            pop      = 1'b1;
            sel_addr = stack_mem[top_idx];
          end
        end
        C_RSV:  take = 1'b0;
        default: take = 1'b0;
      endcase
    end
  end

  // Flag register, outputs, stack pointer and sticky errors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      c_q         <= 1'b0;
      pre_load_q  <= 1'b0;
      load_addr_q <= '0;
      stack_cnt_q <= 5'd0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, whatever the statement order.
      if (bus.flag_we) begin
        z_q <= (bus.W == '0);
        n_q <= bus.W[WIDTH-1];
        c_q <= bus.CY;
      end
      pre_load_q <= take;
      if (take) load_addr_q <= sel_addr;
      if (push)     stack_cnt_q <= stack_cnt_q + 5'd1;
      else if (pop) stack_cnt_q <= stack_cnt_q - 5'd1;
      // A new error in the same cycle as err_clr wins over the clear
      ovf_q <= set_ovf | (ovf_q & ~bus.err_clr);
      unf_q <= set_unf | (unf_q & ~bus.err_clr);
    end
  end

  // Return-address storage
  always_ff @(posedge clk) begin
    // NOTE: stack contents are not reset; validity is tracked by stack_cnt,
    // so clearing the array would only cost reset fan-out.
    if (push) stack_mem[push_idx] <= bus.pc_seq;
  end

  assign bus.pre_load  = pre_load_q;
  assign bus.load_addr = load_addr_q;
  assign bus.stack_cnt = stack_cnt_q;
  assign bus.stack_ovf = ovf_q;
  assign bus.stack_unf = unf_q;

endmodule

// File: tb/tb_unidad_saltos.sv
// tb_unidad_saltos: directed-vector bench for unidad_saltos (WIDTH=16, AW=8,
// DEPTH=4). Expected values are hand-computed constants.
module tb_unidad_saltos;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  logic exp_bypass;

  always #5 clk = ~clk;

  unidad_saltos_if #(.WIDTH(16), .AW(8)) bus ();

  unidad_saltos #(.WIDTH(16), .AW(8), .DEPTH(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [15:0] w, input logic cy);
    bus.flag_we = 1'b1;
    bus.W       = w;
    bus.CY      = cy;
    step();
    bus.flag_we = 1'b0;
  endtask

  task automatic issue(input logic [2:0] c, input logic [7:0] tgt, input logic [7:0] pc);
    bus.instr_valid = 1'b1;
    bus.cond_sel    = c;
    bus.target      = tgt;
    bus.pc_seq      = pc;
    step();
    bus.instr_valid = 1'b0;
  endtask

  initial begin
    bus.flag_we = 0; bus.W = '0; bus.CY = 0; bus.instr_valid = 0;
    bus.cond_sel = 0; bus.target = 0; bus.pc_seq = 0; bus.err_clr = 0;
    #12;
    // Reset values
    check("rst_pre_load", 32'(bus.pre_load), 0);
    check("rst_load_addr", 32'(bus.load_addr), 0);
    check("rst_stack_cnt", 32'(bus.stack_cnt), 0);
    check("rst_ovf", 32'(bus.stack_ovf), 0);
    check("rst_unf", 32'(bus.stack_unf), 0);
    @(negedge clk); rst_n = 1'b1;
    step();

    // 1: unconditional jump, one-cycle pulse
    issue(3'b000, 8'h3C, 8'h01);
    check("jmp_pre_load", 32'(bus.pre_load), 1);
    check("jmp_addr", 32'(bus.load_addr), 32'h3C);
    step();
    check("jmp_pulse_drop", 32'(bus.pre_load), 0);
    check("jmp_addr_hold", 32'(bus.load_addr), 32'h3C);

    // 2: zero / non-zero
    set_flags(16'h0000, 1'b0);
    issue(3'b001, 8'h21, 8'h02);
    check("jze_z1_taken", 32'(bus.pre_load), 1);
    check("jze_z1_addr", 32'(bus.load_addr), 32'h21);
    set_flags(16'h0001, 1'b0);
    issue(3'b001, 8'h22, 8'h03);
    check("jze_z0_not", 32'(bus.pre_load), 0);
    check("jze_z0_hold", 32'(bus.load_addr), 32'h21);
    issue(3'b110, 8'h23, 8'h04);
    check("jnz_taken", 32'(bus.pre_load), 1);
    check("jnz_addr", 32'(bus.load_addr), 32'h23);

    // 3: negative and carry, plus reserved code
    set_flags(16'h8000, 1'b1);
    issue(3'b010, 8'h30, 8'h05);
    check("jne_taken", 32'(bus.pre_load), 1);
    check("jne_addr", 32'(bus.load_addr), 32'h30);
    issue(3'b011, 8'h31, 8'h06);
    check("ccy_c1_taken", 32'(bus.pre_load), 1);
    check("ccy_c1_addr", 32'(bus.load_addr), 32'h31);
    set_flags(16'h8000, 1'b0);
    issue(3'b011, 8'h32, 8'h07);
    check("ccy_c0_not", 32'(bus.pre_load), 0);
    check("ccy_c0_hold", 32'(bus.load_addr), 32'h31);
    issue(3'b111, 8'h33, 8'h08);
    check("rsv_not", 32'(bus.pre_load), 0);
    check("rsv_cnt", 32'(bus.stack_cnt), 0);

    // 4: fill, overflow, drain, underflow
    for (int i = 0; i < 4; i++) begin
      issue(3'b100, 8'(8'h40 + i), 8'(8'h10 + i));
      check("call_taken", 32'(bus.pre_load), 1);
      check("call_addr", 32'(bus.load_addr), 32'(8'h40 + i));
      check("call_cnt", 32'(bus.stack_cnt), 32'(i + 1));
    end
    issue(3'b100, 8'h50, 8'h14);
    check("call_full_not", 32'(bus.pre_load), 0);
    check("call_full_ovf", 32'(bus.stack_ovf), 1);
    check("call_full_cnt", 32'(bus.stack_cnt), 4);
    check("call_full_addr", 32'(bus.load_addr), 32'h43);
    for (int i = 3; i >= 0; i--) begin
      issue(3'b101, 8'hEE, 8'h00);
      check("ret_taken", 32'(bus.pre_load), 1);
      check("ret_addr", 32'(bus.load_addr), 32'(8'h10 + i));
      check("ret_cnt", 32'(bus.stack_cnt), 32'(i));
    end
    issue(3'b101, 8'hEE, 8'h00);
    check("ret_empty_not", 32'(bus.pre_load), 0);
    check("ret_empty_unf", 32'(bus.stack_unf), 1);
    check("ovf_sticky", 32'(bus.stack_ovf), 1);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    check("clr_ovf", 32'(bus.stack_ovf), 0);
    check("clr_unf", 32'(bus.stack_unf), 0);

    // 5: call then ret back to back, then underflow with err_clr
    issue(3'b100, 8'h60, 8'h55);
    check("b2b_call_addr", 32'(bus.load_addr), 32'h60);
    issue(3'b101, 8'hEE, 8'h00);
    check("b2b_ret_taken", 32'(bus.pre_load), 1);
    check("b2b_ret_addr", 32'(bus.load_addr), 32'h55);
    check("b2b_cnt", 32'(bus.stack_cnt), 0);
    bus.err_clr = 1'b1;
    issue(3'b101, 8'hEE, 8'h00);
    bus.err_clr = 1'b0;
    check("clr_vs_set_unf", 32'(bus.stack_unf), 1);
    check("clr_vs_set_pre", 32'(bus.pre_load), 0);

    // 6: same-cycle flag write and jze
    set_flags(16'h0001, 1'b0);
`ifdef UNIDAD_SALTOS_FLAG_BYPASS_EN
    exp_bypass = 1'b1;
`else
    exp_bypass = 1'b0;
`endif
    bus.flag_we = 1'b1;
    bus.W       = 16'h0000;
    issue(3'b001, 8'h70, 8'h09);
    bus.flag_we = 1'b0;
    check("same_cycle_jze", 32'(bus.pre_load), 32'(exp_bypass));
    issue(3'b001, 8'h71, 8'h0A);
    check("next_cycle_jze", 32'(bus.pre_load), 1);
    check("next_cycle_addr", 32'(bus.load_addr), 32'h71);

    // Asynchronous reset with a non-empty stack and a live pulse
    issue(3'b100, 8'h80, 8'h66);
    check("pre_rst_pulse", 32'(bus.pre_load), 1);
    check("pre_rst_cnt", 32'(bus.stack_cnt), 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_pre", 32'(bus.pre_load), 0);
    check("async_rst_cnt", 32'(bus.stack_cnt), 0);
    check("async_rst_addr", 32'(bus.load_addr), 0);
    @(negedge clk); rst_n = 1'b1;
    step();
    issue(3'b101, 8'hEE, 8'h00);
    check("post_rst_unf", 32'(bus.stack_unf), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
